mfcc_mean_accum: RTL and testbench
==================================

// Module: mfcc_mean_accum
// PURPOSE
//  Upstream feeder of the fixed-point divider (div). Per utterance, sums each of NCOEF MFCC
//  coefficients over all frames and counts frames. On utt_end, presents sum_k and frame count
//  to the divider one coefficient at a time, waits out its fixed latency, and streams the means.
//  Sits between the MFCC/DCT output stage and the normalisation stage.
// PARAMETERS
//  WIDTH    40   divider operand/result width; must equal div WIDTH
//  FBITS    16   fractional bits of coef_in, sums and means; must equal div FBITS
//  IN_W     16   signed coef_in width, Q(IN_W-FBITS).FBITS; WIDTH-IN_W >= CNT_W
//  NCOEF    13   coefficients per frame
//  CNT_W    16   frame counter width
//  DIV_WAIT 120  cycles x/y are held before capturing div_q; >= 2*(WIDTH+FBITS)+3
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      synchronous reset, active low
//  coef_valid in   1      coef_in valid
//  in_ready   out  1      block accepts coefficients; transfer = coef_valid & in_ready
//  coef_in    in   IN_W   signed coefficient
//  coef_last  in   1      with transfer: last coefficient of frame
//  utt_end    in   1      one-cycle pulse: end of utterance, start drain
//  div_x      out  WIDTH  to div.x: sign-extended sum of the current coefficient
//  div_y      out  WIDTH  to div.y: frame_cnt << FBITS
//  div_q      in   WIDTH  from div.MFCC_mean
//  mean_valid out  1      one-cycle pulse per mean
//  mean_idx   out  4      coefficient index of mean_out
//  mean_out   out  WIDTH  signed mean, Q.FBITS
//  frame_cnt  out  CNT_W  frames accumulated this utterance
//  frame_err  out  1      sticky: malformed frame seen; cleared by rst_n or drain start
//  busy       out  1      high in LOAD/WAIT/CAPTURE
// BEHAVIOUR
//  Reset: state=ACCUM; sums, coef idx, frame_cnt, div_x, div_y, mean_out, mean_idx=0;
//   in_ready=1; mean_valid=busy=frame_err=0. Reset mid-drain aborts with no further mean_valid.
//  ACCUM: in_ready=1. Per transfer: sum[idx] += sext(coef_in); idx++. On coef_last, or idx==NCOEF-1,
//   idx<=0 and frame_cnt++ (saturates at all-ones; later frames dropped, not summed).
//   coef_last at idx!=NCOEF-1 -> frame_err=1, frame still counted.
//   utt_end -> LOAD, k=0; a same-cycle transfer is applied first. utt_end with idx!=0 sets
//   frame_err; partial-frame values remain in sums, frame not counted.
//  LOAD (1 cyc): div_x<=sum[k], div_y<=frame_cnt<<FBITS, timer<=DIV_WAIT-1 -> WAIT.
//   If frame_cnt==0: skip divider, go straight to CAPTURE with mean 0.
//  WAIT: timer-- each cycle; at 0 -> CAPTURE. x/y held constant throughout.
//  CAPTURE (1 cyc): mean_out<=div_q (or 0), mean_idx<=k, mean_valid=1.
//   k==NCOEF-1 -> CLEAR, else k++ -> LOAD.
//  CLEAR (1 cyc): sums, idx, frame_cnt <= 0 -> ACCUM.
//  in_ready=0 and utt_end ignored from LOAD through CLEAR; coef_valid there is dropped.
//  Latency utt_end -> first mean_valid: DIV_WAIT+2 cycles (2 when frame_cnt==0);
//   period between means: DIV_WAIT+2 cycles (2 when frame_cnt==0).
//  Divider overflow returns 0; passed through unchanged. Sums cannot overflow by parameter rule.
// STRUCTURE
//  mfcc_pkg: WIDTH, FBITS, NCOEF, CNT_W defaults, state enum {ACCUM,LOAD,WAIT,CAPTURE,CLEAR}.
//  Sub-module mfcc_sum_rf: NCOEF x WIDTH register file, one read/accumulate port, sync clear.
//  FSM, timer and counters stay in the top level. div is instantiated by the parent, not here.
// TESTING (bench instantiates div with matching WIDTH/FBITS)
//  1 2 frames, coef k = k<<16 then (k+2)<<16, utt_end -> 13 means, idx 0..12, mean_out=(k+1)<<16.
//  2 coef0 = -3.0, -5.0 over 2 frames -> mean_idx 0, mean_out = -(4<<16) two's complement.
//  3 utt_end with frame_cnt==0 -> 13 zero means, mean_valid every 2 cycles, no DIV_WAIT.
//  4 coef_valid held high during drain -> in_ready=0; next utterance of 1 frame gives exact coefs.
//  5 rst_n low for 1 cycle mid-WAIT on k=4 -> no further mean_valid; next utterance correct.
//  6 coef_last at idx 5 -> frame_err=1, frame_cnt+1, next frame's coef enters sum[0].

Source files
------------

// File: rtl/mfcc_pkg.sv
// mfcc_pkg: shared defaults and drain FSM state encoding for the MFCC mean accumulator
package mfcc_pkg;
  localparam int WIDTH_D    = 40;
  localparam int FBITS_D    = 16;
  localparam int IN_W_D     = 16;
  localparam int NCOEF_D    = 13;
  localparam int CNT_W_D    = 16;
  localparam int DIV_WAIT_D = 120;
  localparam int IDX_W      = 4;
  typedef enum logic [2:0] {ACCUM, LOAD, WAIT, CAPTURE, CLEAR} state_t;
endpackage

// File: rtl/mfcc_mean_accum_if.sv
// mfcc_mean_accum_if: coefficient input, divider operands/result and mean output bundle
//  master: feeder/parent side (drives coef_*, utt_end, div_q)
//  slave : mfcc_mean_accum side (drives in_ready, div_x/y, mean_*, frame_*, busy)
interface mfcc_mean_accum_if import mfcc_pkg::*; #(
  parameter int WIDTH = WIDTH_D,
  parameter int IN_W  = IN_W_D,
  parameter int CNT_W = CNT_W_D
) ();
  logic             coef_valid;
  logic             in_ready;
  logic [IN_W-1:0]  coef_in;
  logic             coef_last;
  logic             utt_end;
  logic [WIDTH-1:0] div_x;
  logic [WIDTH-1:0] div_y;
  logic [WIDTH-1:0] div_q;
  logic             mean_valid;
  logic [IDX_W-1:0] mean_idx;
  logic [WIDTH-1:0] mean_out;
  logic [CNT_W-1:0] frame_cnt;
  logic             frame_err;
  logic             busy;
  modport master (
    output coef_valid, coef_in, coef_last, utt_end, div_q,
    input  in_ready, div_x, div_y, mean_valid, mean_idx, mean_out, frame_cnt, frame_err, busy
  );
  modport slave (
    input  coef_valid, coef_in, coef_last, utt_end, div_q,
    output in_ready, div_x, div_y, mean_valid, mean_idx, mean_out, frame_cnt, frame_err, busy
  );
endinterface

// File: rtl/mfcc_sum_rf.sv
// mfcc_sum_rf: NCOEF x WIDTH per-coefficient sum registers, one read/accumulate port
//  clk, rst_n : clock, synchronous active-low reset
//  clr        : synchronous clear of all sums
//  acc_en     : sum[addr] += acc_val
//  addr       : read/accumulate index
//  rd_data    : sum[addr], combinational
module mfcc_sum_rf #(
  parameter int WIDTH = 40,
  parameter int NCOEF = 13,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             acc_en,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] acc_val,
  output logic [WIDTH-1:0] rd_data
);
  logic [WIDTH-1:0] sum [NCOEF];
  assign rd_data = (32'(addr) < NCOEF) ? sum[addr] : '0;
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      for (int i = 0; i < NCOEF; i++) sum[i] <= '0;
    end else if (acc_en && 32'(addr) < NCOEF) begin
      sum[addr] <= sum[addr] + acc_val;
    end
  end
endmodule

// File: rtl/mfcc_mean_accum.sv
// mfcc_mean_accum: per-utterance MFCC coefficient sums and frame count, drained through an external divider as means
//  clk, rst_n : clock, synchronous active-low reset
//  bus        : coef_valid/in_ready/coef_in/coef_last/utt_end input stream,
//               div_x/div_y/div_q divider operands and result,
//               mean_valid/mean_idx/mean_out output stream, frame_cnt/frame_err/busy status
module mfcc_mean_accum import mfcc_pkg::*; #(
  parameter int WIDTH    = WIDTH_D,
  parameter int FBITS    = FBITS_D,
  parameter int IN_W     = IN_W_D,
  parameter int NCOEF    = NCOEF_D,
  parameter int CNT_W    = CNT_W_D,
  parameter int DIV_WAIT = DIV_WAIT_D
) (
  input logic clk,
  input logic rst_n,
  mfcc_mean_accum_if.slave bus
);
  localparam int TW = $clog2(DIV_WAIT + 1);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NCOEF - 1);
  state_t state, state_n;
  logic [IDX_W-1:0] idx, k, idx_nx;
  logic [TW-1:0] timer;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rd, acc_val, div_x, div_y, mean_out;
  logic [IDX_W-1:0] mean_idx;
  logic mean_valid, frame_err;
  logic xfer, sat, eof, bad_last, cnt_zero, last_k, cap;
  assign bus.in_ready   = state == ACCUM;
  assign bus.busy       = state == LOAD || state == WAIT || state == CAPTURE;
  assign bus.frame_cnt  = cnt;
  assign bus.div_x      = div_x;
  assign bus.div_y      = div_y;
  assign bus.mean_out   = mean_out;
  assign bus.mean_idx   = mean_idx;
  assign bus.mean_valid = mean_valid;
  assign bus.frame_err  = frame_err;
  assign xfer     = bus.coef_valid && state == ACCUM;
  assign sat      = &cnt;
  assign eof      = bus.coef_last || idx == LAST;
  assign bad_last = xfer && bus.coef_last && idx != LAST;
  assign idx_nx   = xfer ? (eof ? '0 : idx + 1'b1) : idx;
  assign cnt_zero = cnt == '0;
  assign last_k   = k == LAST;
  // mean outputs are registered on entry to CAPTURE so mean_valid and mean_out line up in that cycle
  assign cap      = (state == LOAD && cnt_zero) || (state == WAIT && timer == '0);
  assign acc_val  = {{(WIDTH-IN_W){bus.coef_in[IN_W-1]}}, bus.coef_in};
  mfcc_sum_rf #(.WIDTH(WIDTH), .NCOEF(NCOEF), .AW(IDX_W)) u_rf (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (state == CLEAR),
    .acc_en (xfer && !sat),
    .addr   (state == ACCUM ? idx : k),
    .acc_val(acc_val),
    .rd_data(rd)
  );
  always_ff @(posedge clk) state <= !rst_n ? ACCUM : state_n;
  always_comb begin
    state_n = state;
    case (state)
      ACCUM:   state_n = bus.utt_end ? LOAD : ACCUM;
      LOAD:    state_n = cnt_zero ? CAPTURE : WAIT;
      WAIT:    state_n = timer == '0 ? CAPTURE : WAIT;
      CAPTURE: state_n = last_k ? CLEAR : LOAD;
      default: state_n = ACCUM;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx        <= '0;
      k          <= '0;
      cnt        <= '0;
      timer      <= '0;
      div_x      <= '0;
      div_y      <= '0;
      mean_out   <= '0;
      mean_idx   <= '0;
      mean_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      mean_valid <= cap;
      if (cap) begin
        mean_out <= cnt_zero ? '0 : bus.div_q;
        mean_idx <= k;
      end
      if (state == ACCUM) begin
        idx <= idx_nx;
        if (xfer && eof && !sat) cnt <= cnt + 1'b1;
        // drain start restarts the error flag, then flags a trailing partial frame
        if (bus.utt_end) begin
          k         <= '0;
          frame_err <= bad_last || idx_nx != '0;
        end else if (bad_last) begin
          frame_err <= 1'b1;
        end
      end
      if (state == LOAD && !cnt_zero) begin
        div_x <= rd;
        div_y <= WIDTH'({cnt, {FBITS{1'b0}}});
        timer <= TW'(DIV_WAIT - 1);
      end
      if (state == WAIT) timer <= timer - 1'b1;
      if (state == CAPTURE && !last_k) k <= k + 1'b1;
      if (state == CLEAR) begin
        idx <= '0;
        cnt <= '0;
      end
    end
  end
endmodule

// File: tb/tb_mfcc_mean_accum.sv
// tb_mfcc_mean_accum: randomized scoreboard bench for mfcc_mean_accum with a behavioural divider
module tb_mfcc_mean_accum;
  localparam int WIDTH = 40, FBITS = 16, IN_W = 24, NCOEF = 13, CNT_W = 4, DW = 120;
  localparam int CMAX = (1 << CNT_W) - 1;
  typedef struct {int idx; longint mean; int at;} exp_t;
  logic clk = 0, rst_n = 0;
  int cyc = 0, checks = 0, errors = 0;
  exp_t sb[$];
  exp_t me;
  longint msum [NCOEF];
  int midx, mcnt;
  mfcc_mean_accum_if #(.WIDTH(WIDTH), .IN_W(IN_W), .CNT_W(CNT_W)) bus ();
  mfcc_mean_accum #(.WIDTH(WIDTH), .FBITS(FBITS), .IN_W(IN_W), .NCOEF(NCOEF),
    .CNT_W(CNT_W), .DIV_WAIT(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [WIDTH-1:0] divm(logic [WIDTH-1:0] x, logic [WIDTH-1:0] y);
    logic signed [2*WIDTH-1:0] n, d, q;
    n = $signed({{WIDTH{x[WIDTH-1]}}, x});
    n = n <<< FBITS;
    d = $signed({{WIDTH{y[WIDTH-1]}}, y});
    if (d == 0) return '0;
    q = n / d;
    if (q != $signed({{WIDTH{q[WIDTH-1]}}, q[WIDTH-1:0]})) return '0;
    return q[WIDTH-1:0];
  endfunction
  assign bus.div_q = divm(bus.div_x, bus.div_y);
  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at cycle %0d", name, act, req, cyc);
    end
  endtask
  always @(negedge clk) begin
    if (bus.mean_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_mean actual=valid required=none idx=%0d at cycle %0d", bus.mean_idx, cyc);
      end else begin
        me = sb.pop_front();
        chk("mean_idx", longint'(bus.mean_idx), longint'(me.idx));
        chk("mean_out", longint'($signed(bus.mean_out)), me.mean);
        chk("mean_cycle", longint'(cyc), longint'(me.at));
      end
    end
  end
  task automatic model_clear();
    foreach (msum[i]) msum[i] = 0;
    midx = 0;
    mcnt = 0;
  endtask
  task automatic send(input int v, input bit last);
    bus.coef_valid = 1;
    bus.coef_in = IN_W'(v);
    bus.coef_last = last;
    @(posedge clk); #1;
    bus.coef_valid = 0;
    bus.coef_last = 0;
    if (mcnt != CMAX) msum[midx] += v;
    if (last || midx == NCOEF - 1) begin
      midx = 0;
      if (mcnt != CMAX) mcnt++;
    end else midx++;
    if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
  endtask
  function automatic int rnd();
    return int'($urandom_range(0, 1 << (IN_W - 1))) - (1 << (IN_W - 2));
  endfunction
  task automatic frame_rand(input int n);
    for (int i = 0; i < n; i++) send(rnd(), i == n - 1);
  endtask
  task automatic push_means(input int c, output int p);
    p = mcnt == 0 ? 2 : DW + 2;
    for (int i = 0; i < NCOEF; i++)
      sb.push_back('{idx: i, mean: mcnt == 0 ? 0 : msum[i] / mcnt, at: c + (i + 1) * p});
  endtask
  task automatic drain(input string tag, input bit hold);
    int c, p, bad;
    bit part;
    part = midx != 0;
    c = cyc;
    push_means(c, p);
    bus.utt_end = 1;
    bad = 0;
    @(posedge clk); #1;
    bus.utt_end = 0;
    bus.coef_valid = hold;
    chk({tag, "_busy_start"}, longint'(bus.busy), 1);
    while (cyc <= c + NCOEF * p + 1) begin
      if (bus.in_ready) bad++;
      if (cyc == c + NCOEF * p + 1) chk({tag, "_busy_clear"}, longint'(bus.busy), 0);
      @(posedge clk); #1;
      bus.coef_in = IN_W'(rnd());
      bus.coef_last = hold & $urandom_range(0, 1);
    end
    bus.coef_valid = 0;
    bus.coef_last = 0;
    chk({tag, "_in_ready_drain_high_cycles"}, bad, 0);
    chk({tag, "_in_ready_after"}, longint'(bus.in_ready), 1);
    chk({tag, "_means_pending"}, sb.size(), 0);
    chk({tag, "_frame_cnt_after"}, longint'(bus.frame_cnt), 0);
    chk({tag, "_frame_err_after"}, longint'(bus.frame_err), longint'(part));
    sb.delete();
    model_clear();
  endtask
  task automatic idle_state(input string tag);
    chk({tag, "_in_ready"}, longint'(bus.in_ready), 1);
    chk({tag, "_busy"}, longint'(bus.busy), 0);
    chk({tag, "_mean_valid"}, longint'(bus.mean_valid), 0);
    chk({tag, "_frame_cnt"}, longint'(bus.frame_cnt), 0);
    chk({tag, "_frame_err"}, longint'(bus.frame_err), 0);
    chk({tag, "_mean_out"}, longint'(bus.mean_out), 0);
    chk({tag, "_mean_idx"}, longint'(bus.mean_idx), 0);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int c, p;
    bus.coef_valid = 0;
    bus.coef_in = '0;
    bus.coef_last = 0;
    bus.utt_end = 0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1;
    idle_state("reset");
    chk("reset_div_x", longint'(bus.div_x), 0);
    chk("reset_div_y", longint'(bus.div_y), 0);
    for (int f = 0; f < 2; f++)
      for (int k = 0; k < NCOEF; k++) send((k + 2 * f) << FBITS, k == NCOEF - 1);
    chk("t1_frame_cnt", longint'(bus.frame_cnt), 2);
    chk("t1_mean5_model", msum[5] / mcnt, longint'(6 << FBITS));
    drain("t1", 0);
    send(-3 << FBITS, 0);
    for (int k = 1; k < NCOEF; k++) send(rnd(), k == NCOEF - 1);
    send(-5 << FBITS, 0);
    for (int k = 1; k < NCOEF; k++) send(rnd(), k == NCOEF - 1);
    chk("t2_mean0_model", msum[0] / mcnt, -longint'(4 << FBITS));
    drain("t2", 0);
    drain("t3_zero", 0);
    frame_rand(NCOEF);
    frame_rand(NCOEF);
    drain("t4_hold", 1);
    frame_rand(NCOEF);
    drain("t4_next", 0);
    frame_rand(NCOEF);
    frame_rand(NCOEF);
    c = cyc;
    push_means(c, p);
    bus.utt_end = 1;
    @(posedge clk); #1;
    bus.utt_end = 0;
    while (cyc < c + 4 * p + 12) begin @(posedge clk); #1; end
    chk("t5_busy_wait", longint'(bus.busy), 1);
    chk("t5_idx_before_reset", longint'(bus.mean_idx), 3);
    rst_n = 0;
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1;
    model_clear();
    repeat (300) begin @(posedge clk); #1; end
    idle_state("t5_after_reset");
    frame_rand(NCOEF);
    frame_rand(NCOEF);
    frame_rand(NCOEF);
    drain("t5_next", 0);
    frame_rand(6);
    chk("t6_frame_err", longint'(bus.frame_err), 1);
    chk("t6_frame_cnt", longint'(bus.frame_cnt), 1);
    frame_rand(NCOEF);
    chk("t6_frame_cnt2", longint'(bus.frame_cnt), 2);
    drain("t6", 0);
    for (int u = 0; u < 3; u++) begin
      int nf;
      nf = $urandom_range(1, 4);
      for (int f = 0; f < nf; f++) frame_rand(NCOEF);
      if (u == 1) frame_rand(4);
      chk("rand_frame_cnt", longint'(bus.frame_cnt), mcnt);
      drain("rand", 0);
    end
    for (int f = 0; f < CMAX + 2; f++) frame_rand(NCOEF);
    chk("sat_frame_cnt", longint'(bus.frame_cnt), CMAX);
    drain("sat", 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
